// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings and the
// conditional-branch opcode.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SN = 2'b00,
      WN = 2'b01,
      WT = 2'b10,
      ST = 2'b11
   } ctr_state_t;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   function automatic logic ctr_predicts_taken(input ctr_state_t s);
      return s[1];
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-state logic, purely combinational.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  ctr_state_t state,
   input  logic       taken,
   output ctr_state_t next_state
);

   always_comb begin
      next_state = state;
      if (taken) begin
         unique case (state)
            SN: next_state = WN;
            WN: next_state = WT;
            WT: next_state = ST;
            ST: next_state = ST;
         endcase
      end else begin
         unique case (state)
            SN: next_state = SN;
            WN: next_state = SN;
            WT: next_state = WN;
            ST: next_state = WT;
         endcase
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// pc[IDX_W+1:2], with a registered lookup path and resolved-branch statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   output logic        pred_out_valid,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic        upd_pred,
   output logic        mispredict,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   // Flop array so that every entry can be cleared by the async reset.
   ctr_state_t       table_q [ENTRIES];
   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] upd_idx;
   ctr_state_t       upd_cur;
   ctr_state_t       upd_next;
   ctr_state_t       pred_cur;
   logic             is_mispred;

   logic             pred_out_valid_q;
   logic             pred_taken_q;
   logic             mispredict_q;
   logic [31:0]      branch_cnt_q;
   logic [31:0]      mispred_cnt_q;

   logic             unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                             upd_pc[31:IDX_W+2], upd_pc[1:0]};

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign upd_idx  = upd_pc[IDX_W+1:2];
   assign upd_cur  = table_q[upd_idx];

   sat_counter2 u_sat_counter2 (
      .state      (upd_cur),
      .taken      (upd_taken),
      .next_state (upd_next)
   );

   // A lookup colliding with an update sees the post-update value.
   always_comb begin
      pred_cur = table_q[pred_idx];
      if (upd_valid && (upd_idx == pred_idx)) begin
         pred_cur = upd_next;
      end
   end

   assign is_mispred = upd_valid && (upd_taken != upd_pred);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= WN;
         end
      end else if (upd_valid) begin
         table_q[upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_out_valid_q <= 1'b0;
         pred_taken_q     <= 1'b0;
      end else begin
         pred_out_valid_q <= pred_valid;
         if (pred_valid) begin
            pred_taken_q <= ctr_predicts_taken(pred_cur);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict_q  <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         mispredict_q <= is_mispred;
         if (upd_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
         end
         if (is_mispred) begin
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
         end
      end
   end

   assign pred_out_valid = pred_out_valid_q;
   assign pred_taken     = pred_taken_q;
   assign mispredict     = mispredict_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expectations into
// queues, a monitor pops and compares each cycle.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_out_valid;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred;
   logic        mispredict;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int tests = 0;
   int fails = 0;
   logic mon_en = 1'b0;

   typedef struct packed {
      logic ov;
      logic mp;
   } cyc_exp_t;

   cyc_exp_t cyc_q [$];
   logic     pred_q [$];

   branch_predictor #(.IDX_W(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_out_valid (pred_out_valid),
      .pred_taken     (pred_taken),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_pred       (upd_pred),
      .mispredict     (mispredict),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one per-cycle expectation, plus a prediction whenever valid.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (cyc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL cyc_queue_empty: got empty expected entry at %0t", $time);
         end else begin
            cyc_exp_t e;
            e = cyc_q.pop_front();
            check("pred_out_valid", {31'd0, pred_out_valid}, {31'd0, e.ov});
            check("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
         end
         if (pred_out_valid) begin
            if (pred_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pred_queue_empty: got unexpected prediction at %0t", $time);
            end else begin
               logic ep;
               ep = pred_q.pop_front();
               check("pred_taken", {31'd0, pred_taken}, {31'd0, ep});
            end
         end
      end
   end

   task automatic cycle(input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic up,
                        input logic exp_pt, input logic exp_mp);
      cyc_exp_t e;
      @(negedge clk);
      pred_valid = pv;
      pred_pc    = ppc;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_pred   = up;
      e.ov = pv;
      e.mp = exp_mp;
      cyc_q.push_back(e);
      if (pv) pred_q.push_back(exp_pt);
      @(posedge clk);
      #2;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic exp_pt);
      cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, exp_pt, 1'b0);
   endtask

   task automatic update(input logic [31:0] pc, input logic t, input logic p, input logic exp_mp);
      cycle(1'b0, 32'h0, 1'b1, pc, t, p, 1'b0, exp_mp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pred_out_valid"}, {31'd0, pred_out_valid}, 32'd0);
      check({tag, "_pred_taken"}, {31'd0, pred_taken}, 32'd0);
      check({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
      check({tag, "_branch_cnt"}, branch_cnt, 32'd0);
      check({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
      for (int i = 0; i < 16; i++) begin
         check({tag, "_table_wn"}, {30'd0, dut.table_q[i]}, {30'd0, WN});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      pred_valid = 1'b0;
      pred_pc    = '0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_pred   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("por");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      lookup(32'h0000_0040, 1'b0);
      update(32'h0000_0040, 1'b1, 1'b0, 1'b1);
      update(32'h0000_0040, 1'b1, 1'b0, 1'b1);
      lookup(32'h0000_0040, 1'b1);
      check("branch_cnt_2", branch_cnt, 32'd2);
      check("mispred_cnt_2", mispred_cnt, 32'd2);

      repeat (4) update(32'h0000_0040, 1'b1, 1'b1, 1'b0);
      update(32'h0000_0040, 1'b0, 1'b1, 1'b1);
      lookup(32'h0000_0040, 1'b1);
      repeat (3) update(32'h0000_0040, 1'b0, 1'b0, 1'b0);
      lookup(32'h0000_0040, 1'b0);
      check("branch_cnt_10", branch_cnt, 32'd10);
      check("mispred_cnt_3", mispred_cnt, 32'd3);

      // Entry 0 back to WN, then a colliding lookup/update at 0x80 (index 0).
      update(32'h0000_0040, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0048, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b0, 1'b0);

      lookup(32'h0000_0048, 1'b0);
      lookup(32'h0000_0084, 1'b1);
      cycle(1'b0, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold_pred_taken", {31'd0, pred_taken}, 32'd1);
      lookup(32'hFFFF_FF87, 1'b1);
      check("branch_cnt_13", branch_cnt, 32'd13);
      check("mispred_cnt_4", mispred_cnt, 32'd4);

      dut.branch_cnt_q  = 32'hFFFF_FFFF;
      dut.mispred_cnt_q = 32'hFFFF_FFFF;
      update(32'h0000_0044, 1'b0, 1'b1, 1'b1);
      check("branch_cnt_wrap", branch_cnt, 32'd0);
      check("mispred_cnt_wrap", mispred_cnt, 32'd0);

      // Async reset mid-cycle with a lookup and update in flight.
      @(negedge clk);
      mon_en     = 1'b0;
      pred_valid = 1'b1;
      pred_pc    = 32'h0000_0084;
      upd_valid  = 1'b1;
      upd_pc     = 32'h0000_0044;
      upd_taken  = 1'b1;
      upd_pred   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      pred_valid = 1'b0;
      upd_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      lookup(32'h0000_0084, 1'b0);
      lookup(32'h0000_0040, 1'b0);
      check("branch_cnt_post_rst", branch_cnt, 32'd0);

      @(negedge clk);
      mon_en = 1'b0;
      check("cyc_queue_drained", cyc_q.size(), 32'd0);
      check("pred_queue_drained", pred_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
